// File: rtl/geofence_feeder_pkg.sv
// geofence_pkg: shared constants, point bundle and feeder FSM states.
// Frame = target + 6 fence vertices, 10-bit coords, 16-bit result count.
package geofence_pkg;

  localparam int FRAME   = 7;
  localparam int COORD_W = 10;
  localparam int CNT_W   = 16;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pt_t;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    BURST = 2'd1,
    WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/geofence_feeder_if.sv
// geofence_feeder_if: valid/ready point stream into the feeder.
// master drives in_valid/in_x/in_y, slave returns in_ready.
interface geofence_feeder_if;

  logic                              in_valid;
  logic                              in_ready;
  logic [geofence_pkg::COORD_W-1:0] in_x;
  logic [geofence_pkg::COORD_W-1:0] in_y;

  modport master (
    output in_valid, in_x, in_y,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_x, in_y,
    output in_ready
  );

endinterface

// File: rtl/geofence_fifo.sv
// geofence_fifo: circular point FIFO, same-cycle push/pop, count out.
// Ports: clk, reset, push, pop, din, dout (head), count.
module geofence_fifo
  import geofence_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  pt_t           din,
  output pt_t           dout,
  output logic [CW-1:0] count
);

  pt_t mem [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wptr_d  = push ? nxt(wptr_q) : wptr_q;
    rptr_d  = pop  ? nxt(rptr_q) : rptr_q;
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (pop && !push)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr_q] <= din;
  end

  assign dout  = mem[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/geofence_feeder.sv
// geofence_feeder: buffers points, bursts 7-point frames into the core.
// Ports: clk, reset, in_if (slave), core_rst/x/y, core_valid/inside, res_*, frame_cnt.
module geofence_feeder
  import geofence_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  geofence_feeder_if.slave   in_if,
  output logic               core_rst,
  output logic [COORD_W-1:0] core_x,
  output logic [COORD_W-1:0] core_y,
  input  logic               core_valid,
  input  logic               core_inside,
  output logic               res_valid,
  output logic               res_inside,
  output logic [CNT_W-1:0]   frame_cnt
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] count;
  pt_t           din;
  pt_t           head;
  logic          push;
  logic          pop;
  logic          full_frame;

  state_e           state_q, state_d;
  logic [2:0]       beat_q, beat_d;
  logic             core_rst_q, core_rst_d;
  logic             res_valid_q, res_valid_d;
  logic             res_inside_q, res_inside_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             take_res;

  assign in_if.in_ready = (count < CW'(DEPTH));
  assign push       = in_if.in_valid && in_if.in_ready;
  assign pop        = (state_q == BURST);
  assign full_frame = (count >= CW'(FRAME));
  assign din        = {in_if.in_x, in_if.in_y};

  geofence_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .count (count)
  );

  // Results are only taken while a frame is outstanding.
  assign take_res = core_valid && (state_q == WAIT);

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    core_rst_d   = core_rst_q;
    res_valid_d  = take_res;
    res_inside_d = take_res ? core_inside : res_inside_q;
    frame_cnt_d  = take_res ? frame_cnt_q + 1'b1
                            : frame_cnt_q;
    unique case (state_q)
      HOLD: begin
        if (full_frame) begin
          state_d    = BURST;
          beat_d     = '0;
          core_rst_d = 1'b0;
        end
      end
      BURST: begin
        beat_d = beat_q + 3'd1;
        if (beat_q == 3'(FRAME - 1)) begin
          state_d = WAIT;
          beat_d  = '0;
        end
      end
      WAIT: begin
        // Count from this cycle only: a same-cycle push cannot
        // complete a frame in time for a zero-bubble restart.
        if (core_valid) begin
          if (full_frame) begin
            state_d = BURST;
            beat_d  = '0;
          end else begin
            state_d    = HOLD;
            core_rst_d = 1'b1;
          end
        end
      end
      default: begin
        state_d    = HOLD;
        beat_d     = '0;
        core_rst_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= HOLD;
      beat_q       <= '0;
      core_rst_q   <= 1'b1;
      res_valid_q  <= 1'b0;
      res_inside_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      core_rst_q   <= core_rst_d;
      res_valid_q  <= res_valid_d;
      res_inside_q <= res_inside_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign core_x     = pop ? head.x : '0;
  assign core_y     = pop ? head.y : '0;
  assign core_rst   = core_rst_q;
  assign res_valid  = res_valid_q;
  assign res_inside = res_inside_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_geofence_feeder.sv
// tb_geofence_feeder: directed frames, behavioural hexagon core,
// point and result scoreboards.
module tb_geofence_feeder;
  import geofence_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  geofence_feeder_if in_if();

  logic        core_rst;
  logic [9:0]  core_x, core_y;
  logic        core_valid, core_inside;
  logic        cv_m = 1'b0;
  logic        ci_m = 1'b0;
  logic        stray = 1'b0;
  logic        res_valid, res_inside;
  logic [15:0] frame_cnt;

  assign core_valid  = cv_m | stray;
  assign core_inside = ci_m;

  geofence_feeder #(
    .DEPTH (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_if       (in_if),
    .core_rst    (core_rst),
    .core_x      (core_x),
    .core_y      (core_y),
    .core_valid  (core_valid),
    .core_inside (core_inside),
    .res_valid   (res_valid),
    .res_inside  (res_inside),
    .frame_cnt   (frame_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_res = 0;
  int exp_cnt = 0;
  logic [19:0] pt_q[$];
  bit          res_q[$];
  bit          hold_valid = 1'b0;

  int hx[6] = '{0, 30, 70, 100, 70, 30};
  int hy[6] = '{40, 0, 0, 40, 90, 90};

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Behavioural core: samples target + 6 vertices, answers after 3 cycles.
  int mode = 0;
  int k = 0;
  int d = 0;
  int px[7];
  int py[7];

  function automatic bit hex_in();
    int pos = 0;
    int neg = 0;
    for (int i = 0; i < 6; i++) begin
      int x1 = px[1 + i];
      int y1 = py[1 + i];
      int x2 = px[1 + (i + 1) % 6];
      int y2 = py[1 + (i + 1) % 6];
      int c = (x2 - x1) * (py[0] - y1) - (y2 - y1) * (px[0] - x1);
      if (c > 0) pos++;
      if (c < 0) neg++;
    end
    return (pos == 6) || (neg == 6);
  endfunction

  always @(negedge clk) begin
    if (reset || core_rst) begin
      mode = 0;
      k = 0;
      cv_m = 1'b0;
    end else begin
      if (mode == 2) begin
        cv_m = 1'b0;
        mode = 0;
        k = 0;
      end
      if (mode == 0) begin
        chk("beat_avail", int'(pt_q.size() > 0), 1);
        if (pt_q.size() > 0) begin
          logic [19:0] e;
          e = pt_q.pop_front();
          chk("beat_x", int'(core_x), int'(e[19:10]));
          chk("beat_y", int'(core_y), int'(e[9:0]));
        end
        px[k] = int'(core_x);
        py[k] = int'(core_y);
        k++;
        if (k == 7) begin
          mode = 1;
          d = 0;
        end
      end else if (mode == 1) begin
        chk("wait_xy_zero", int'({core_x, core_y}), 0);
        if (!hold_valid) d++;
        if (d == 3) begin
          cv_m = 1'b1;
          ci_m = hex_in();
          mode = 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && res_valid) begin
      n_res++;
      if (res_q.size() == 0) begin
        chk("res_unexpected", 1, 0);
      end else begin
        bit e;
        e = res_q.pop_front();
        exp_cnt++;
        chk("res_inside", int'(res_inside), int'(e));
        chk("frame_cnt", int'(frame_cnt), exp_cnt);
      end
    end
  end

  task automatic push_pt(int x, int y);
    int t = 0;
    @(negedge clk);
    in_if.in_valid = 1'b1;
    in_if.in_x = 10'(x);
    in_if.in_y = 10'(y);
    while (!in_if.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_if.in_ready) begin
      chk("push_timeout", 0, 1);
      in_if.in_valid = 1'b0;
      return;
    end
    pt_q.push_back({10'(x), 10'(y)});
    @(posedge clk);
    #1 in_if.in_valid = 1'b0;
  endtask

  task automatic push_frame(int tx, int ty);
    push_pt(tx, ty);
    for (int i = 0; i < 6; i++) push_pt(hx[i], hy[i]);
  endtask

  task automatic wait_res(int n);
    int t = 0;
    while (n_res < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("res_arrived", int'(n_res >= n), 1);
  endtask

  initial begin
    in_if.in_valid = 1'b0;
    in_if.in_x = '0;
    in_if.in_y = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: idle after reset
    repeat (20) begin
      @(negedge clk);
      chk("t1_core_rst", int'(core_rst), 1);
      chk("t1_in_ready", int'(in_if.in_ready), 1);
      chk("t1_res_valid", int'(res_valid), 0);
      chk("t1_frame_cnt", int'(frame_cnt), 0);
      chk("t1_core_x", int'(core_x), 0);
    end

    // 2: one inside frame
    res_q.push_back(1'b1);
    push_frame(50, 50);
    wait_res(1);
    @(negedge clk);
    chk("t2_core_rst_back", int'(core_rst), 1);

    // 3: two frames back to back, core never reset in between
    res_q.push_back(1'b1);
    res_q.push_back(1'b0);
    push_frame(50, 50);
    push_frame(200, 200);
    begin
      int t = 0;
      while (n_res < 2 && t < 200) begin
        @(negedge clk);
        chk("t3_rst_low", int'(core_rst), 0);
        t++;
      end
    end
    wait_res(3);
    @(negedge clk);
    chk("t3_core_rst_back", int'(core_rst), 1);

    // 4: starvation at 6 points, stray core_valid ignored
    push_pt(95, 80);
    for (int i = 0; i < 5; i++) push_pt(hx[i], hy[i]);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      stray = (c == 10);
      chk("t4_core_rst", int'(core_rst), 1);
      chk("t4_core_x", int'(core_x), 0);
    end
    stray = 1'b0;
    @(negedge clk);
    chk("t4_frame_cnt", int'(frame_cnt), 3);
    res_q.push_back(1'b0);
    push_pt(hx[5], hy[5]);
    @(negedge clk);
    chk("t4_rst_still_hi", int'(core_rst), 1);
    @(negedge clk);
    chk("t4_rst_fall", int'(core_rst), 0);
    wait_res(4);

    // 5: backpressure with the first result held off
    hold_valid = 1'b1;
    res_q.push_back(1'b1);
    res_q.push_back(1'b0);
    res_q.push_back(1'b1);
    push_frame(10, 40);
    push_frame(200, 200);
    push_frame(60, 20);
    push_pt(50, 50);
    push_pt(hx[0], hy[0]);
    @(negedge clk);
    chk("t5_full_ready", int'(in_if.in_ready), 0);
    in_if.in_valid = 1'b1;
    in_if.in_x = 10'd1023;
    in_if.in_y = 10'd1023;
    repeat (5) begin
      chk("t5_blocked_ready", int'(in_if.in_ready), 0);
      @(negedge clk);
    end
    in_if.in_valid = 1'b0;
    hold_valid = 1'b0;
    wait_res(7);
    res_q.push_back(1'b1);
    for (int i = 1; i < 6; i++) push_pt(hx[i], hy[i]);
    wait_res(8);

    // 6: reset in the middle of a burst
    push_frame(50, 50);
    begin
      int t = 0;
      while (core_rst && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk("t6_burst_start", int'(core_rst), 0);
    end
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    pt_q.delete();
    exp_cnt = 0;
    @(negedge clk);
    chk("t6_core_rst", int'(core_rst), 1);
    chk("t6_frame_cnt", int'(frame_cnt), 0);
    chk("t6_in_ready", int'(in_if.in_ready), 1);
    chk("t6_res_valid", int'(res_valid), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_idle_rst", int'(core_rst), 1);
    res_q.push_back(1'b1);
    push_frame(60, 20);
    wait_res(9);

    repeat (5) @(negedge clk);
    chk("tail_pts_left", pt_q.size(), 0);
    chk("tail_res_left", res_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
